// File: rtl/sprite_line_eval_pkg.sv
// sprite_line_eval_pkg: constants and helpers shared by the sprite line
// evaluator, the line buffer and the compositor. Covers the FSM state
// encodings, the visible line width, the lb_wrdata field layout and the
// pixel nibble ordering inside a 32-bit VRAM pattern word.
// The optional per-line sprite limit is enabled by defining the
// macro SPRITE_LINE_LIMIT_EN (see sprite_line_eval.sv).
package sprite_line_eval_pkg;

    localparam int NUM_SPR = 64;   // attribute entries scanned per line
    localparam int MAX_SPR = 16;   // sprites rendered per line when limited
    localparam int LINE_W  = 320;  // visible width; x >= LINE_W is dropped

    localparam logic [5:0] LAST_SPR = 6'(NUM_SPR - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_RENDER = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Pixel p of a pattern word lives in bits [31-4p -: 4]; pixel 0 is leftmost.
    function automatic logic [3:0] pixel_nibble(input logic [31:0] row,
                                                input logic [2:0]  p);
        return row[5'd31 - {p, 2'b00} -: 4];
    endfunction

    // Line buffer word: {priority, palette[1:0], color[3:0]}.
    function automatic logic [6:0] lb_pack(input logic       priority_flag,
                                           input logic [1:0] palette,
                                           input logic [3:0] color);
        return {priority_flag, palette, color};
    endfunction

endpackage

// File: rtl/sprite_line_eval_spr_row_shifter.sv
// spr_row_shifter: holds one fetched 8-pixel pattern row and steps through
// it one pixel per cycle, honouring horizontal flip. Reports the screen
// pixel offset being produced and flags the eighth pixel.
module spr_row_shifter
    import sprite_line_eval_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] data,
    input  logic        advance,
    input  logic        hflip,
    output logic [3:0]  nibble,
    output logic [2:0]  pix,
    output logic        last
);

    logic [31:0] row;
    logic [2:0]  cnt;

    // Capture a new pattern row, or step to the next screen pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the row data is reset along with the counter so the nibble output is never X after power-up.
            row <= '0;
            cnt <= '0;
        end else if (load) begin
            // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
            row <= data;
            cnt <= '0;
        end else if (advance) begin
            cnt <= cnt + 3'd1;
        end
    end

    // With hflip the screen pixel p comes from source pixel 7-p (~p on 3 bits).
    assign nibble = pixel_nibble(row, hflip ? ~cnt : cnt);
    assign pix    = cnt;
    assign last   = (cnt == 3'd7);

endmodule

// File: rtl/sprite_line_eval.sv
// sprite_line_eval: per-scanline sprite evaluator and renderer. Scans all
// 64 attribute entries for the next line, fetches the 4bpp pattern row of
// each hitting sprite from VRAM and writes its opaque, on-screen pixels to
// the sprite line buffer (which keeps the first write per x).
// Optional feature macro: SPRITE_LINE_LIMIT_EN caps rendering at MAX_SPR
// sprites per line and raises spr_overflow; undefined, every hit renders.
module sprite_line_eval
    import sprite_line_eval_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  line_num,
    output logic        busy,
    output logic [5:0]  spr_sel,
    input  logic [8:0]  spr_x,
    input  logic [7:0]  spr_y,
    input  logic [9:0]  spr_idx,
    input  logic        spr_priority,
    input  logic [1:0]  spr_palette,
    input  logic        spr_h16,
    input  logic        spr_vflip,
    input  logic        spr_hflip,
    output logic [12:0] vram_addr,
    output logic        vram_req,
    input  logic        vram_ack,
    input  logic [31:0] vram_rddata,
    output logic [8:0]  lb_addr,
    output logic [6:0]  lb_wrdata,
    output logic        lb_wren,
    output logic        spr_overflow
);

    logic [2:0] state;
    logic [7:0] line_reg;
    logic [8:0] x_reg;
    logic       pri_reg;
    logic [1:0] pal_reg;
    logic       hflip_reg;

    logic [7:0] dy;
    logic       hit;
    logic [3:0] row;
    logic [9:0] tile;
    logic [9:0] px;
    logic [3:0] nibble;
    logic [2:0] pix;
    logic       last;
    logic       at_limit;

    // Hit test and pattern row selection for the entry on spr_sel, plus the
    // 10-bit screen x of the pixel being rendered (no wrap past 511).
    always_comb begin
        // NOTE: every signal here is assigned on every path, so no latch can be inferred.
        dy   = line_reg - spr_y;
        hit  = spr_h16 ? (dy < 8'd16) : (dy < 8'd8);
        row  = spr_vflip ? ((spr_h16 ? 4'd15 : 4'd7) - dy[3:0]) : dy[3:0];
        tile = spr_idx + {9'd0, row[3]};
        px   = {1'b0, x_reg} + {7'd0, pix};
    end

    spr_row_shifter u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load    ((state == ST_FETCH) && vram_ack && !line_start),
        .data    (vram_rddata),
        .advance ((state == ST_RENDER) && !line_start),
        .hflip   (hflip_reg),
        .nibble  (nibble),
        .pix     (pix),
        .last    (last)
    );

    // Main sequencer: scan, fetch, render; line_start restarts from any state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            spr_sel   <= '0;
            line_reg  <= '0;
            x_reg     <= '0;
            pri_reg   <= 1'b0;
            pal_reg   <= '0;
            hflip_reg <= 1'b0;
            vram_req  <= 1'b0;
            vram_addr <= '0;
            lb_wren   <= 1'b0;
            lb_addr   <= '0;
            lb_wrdata <= '0;
        end else begin
            lb_wren <= 1'b0;
            if (line_start) begin
                line_reg <= line_num;
                spr_sel  <= '0;
                busy     <= 1'b1;
                vram_req <= 1'b0;
                state    <= ST_SCAN;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_SCAN: begin
                        if (hit && at_limit) begin
                            state <= ST_DONE;
                        end else if (hit) begin
                            x_reg     <= spr_x;
                            pri_reg   <= spr_priority;
                            pal_reg   <= spr_palette;
                            hflip_reg <= spr_hflip;
                            vram_addr <= {tile, row[2:0]};
                            vram_req  <= 1'b1;
                            state     <= ST_FETCH;
                        end else begin
                            spr_sel <= spr_sel + 6'd1;
                            if (spr_sel == LAST_SPR) begin
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (vram_ack) begin
                            vram_req <= 1'b0;
                            state    <= ST_RENDER;
                        end
                    end
                    ST_RENDER: begin
                        lb_wren   <= (nibble != 4'd0) && (px < 10'(LINE_W));
                        lb_addr   <= px[8:0];
                        lb_wrdata <= lb_pack(pri_reg, pal_reg, nibble);
                        if (last) begin
                            spr_sel <= spr_sel + 6'd1;
                            state   <= (spr_sel == LAST_SPR) ? ST_DONE : ST_SCAN;
                        end
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SPRITE_LINE_LIMIT_EN
    logic [4:0] count;

    assign at_limit = (count == 5'(MAX_SPR));

    // Rendered-sprite count and sticky overflow flag for the current line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            spr_overflow <= 1'b0;
        end else if (line_start) begin
            count        <= '0;
            spr_overflow <= 1'b0;
        end else if ((state == ST_SCAN) && hit && at_limit) begin
            spr_overflow <= 1'b1;
        end else if ((state == ST_RENDER) && last) begin
            count <= count + 5'd1;
        end
    end
`else
    assign at_limit     = 1'b0;
    assign spr_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_line_eval.sv
// tb_sprite_line_eval: directed bench for sprite_line_eval. A bench-side
// attribute table and VRAM respond to the DUT; a behavioural model derives
// the expected fetch addresses and line-buffer writes for each line, and a
// compare process checks them as they occur. Literal checks pin the model.
`timescale 1ns/1ps
module tb_sprite_line_eval;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [7:0]  line_num;
    logic        busy;
    logic [5:0]  spr_sel;
    logic [8:0]  spr_x;
    logic [7:0]  spr_y;
    logic [9:0]  spr_idx;
    logic        spr_priority;
    logic [1:0]  spr_palette;
    logic        spr_h16;
    logic        spr_vflip;
    logic        spr_hflip;
    logic [12:0] vram_addr;
    logic        vram_req;
    logic        vram_ack;
    logic [31:0] vram_rddata;
    logic [8:0]  lb_addr;
    logic [6:0]  lb_wrdata;
    logic        lb_wren;
    logic        spr_overflow;

    // Attribute store and VRAM contents
    logic [8:0]  a_x   [64];
    logic [7:0]  a_y   [64];
    logic [9:0]  a_idx [64];
    logic        a_pri [64];
    logic [1:0]  a_pal [64];
    logic        a_h16 [64];
    logic        a_vf  [64];
    logic        a_hf  [64];
    logic [31:0] mem   [8192];

    logic [15:0] exp_wr[$];
    logic [12:0] exp_fetch[$];
    logic [15:0] act_wr[$];
    logic [12:0] act_fetch[$];
    logic        exp_ovf;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  check_en = 1'b1;
    bit  hold_ack = 1'b0;
    int  lat = 0;

    sprite_line_eval dut (
        .clk          (clk),
        .reset        (reset),
        .line_start   (line_start),
        .line_num     (line_num),
        .busy         (busy),
        .spr_sel      (spr_sel),
        .spr_x        (spr_x),
        .spr_y        (spr_y),
        .spr_idx      (spr_idx),
        .spr_priority (spr_priority),
        .spr_palette  (spr_palette),
        .spr_h16      (spr_h16),
        .spr_vflip    (spr_vflip),
        .spr_hflip    (spr_hflip),
        .vram_addr    (vram_addr),
        .vram_req     (vram_req),
        .vram_ack     (vram_ack),
        .vram_rddata  (vram_rddata),
        .lb_addr      (lb_addr),
        .lb_wrdata    (lb_wrdata),
        .lb_wren      (lb_wren),
        .spr_overflow (spr_overflow)
    );

    always #5 clk = ~clk;

    assign spr_x        = a_x[spr_sel];
    assign spr_y        = a_y[spr_sel];
    assign spr_idx      = a_idx[spr_sel];
    assign spr_priority = a_pri[spr_sel];
    assign spr_palette  = a_pal[spr_sel];
    assign spr_h16      = a_h16[spr_sel];
    assign spr_vflip    = a_vf[spr_sel];
    assign spr_hflip    = a_hf[spr_sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] wr(input int x, input int pri, input int pal, input int c);
        return {x[8:0], pri[0], pal[1:0], c[3:0]};
    endfunction

    // Expected fetches and writes for one line, straight from the sprite rules.
    function automatic void build_expect(input int line);
        int rendered = 0;
        exp_wr.delete();
        exp_fetch.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < 64; i++) begin
            int dy, h, row, tile, addr, src, nib, x;
            logic [31:0] word;
            dy = (line - int'(a_y[i]) + 256) % 256;
            h  = a_h16[i] ? 16 : 8;
            if (dy >= h) continue;
`ifdef SPRITE_LINE_LIMIT_EN
            if (rendered == 16) begin
                exp_ovf = 1'b1;
                break;
            end
`endif
            row  = a_vf[i] ? h - 1 - dy : dy;
            tile = (int'(a_idx[i]) + row / 8) % 1024;
            addr = tile * 8 + row % 8;
            exp_fetch.push_back(13'(addr));
            word = mem[addr];
            for (int p = 0; p < 8; p++) begin
                src = a_hf[i] ? 7 - p : p;
                nib = int'((word >> (28 - 4 * src)) & 32'hF);
                x   = int'(a_x[i]) + p;
                if (nib != 0 && x < 320) exp_wr.push_back(wr(x, a_pri[i], a_pal[i], nib));
            end
            rendered++;
        end
    endfunction

    task automatic clear_all();
        for (int i = 0; i < 64; i++) begin
            a_x[i] = '0; a_y[i] = 8'd200; a_idx[i] = '0; a_pri[i] = 1'b0;
            a_pal[i] = '0; a_h16[i] = 1'b0; a_vf[i] = 1'b0; a_hf[i] = 1'b0;
        end
        for (int i = 0; i < 8192; i++) mem[i] = '0;
    endtask

    task automatic set_spr(input int i, input int x, input int y, input int idx, input int pri,
                           input int pal, input int h16, input int vf, input int hf);
        a_x[i] = 9'(x); a_y[i] = 8'(y); a_idx[i] = 10'(idx); a_pri[i] = pri[0];
        a_pal[i] = 2'(pal); a_h16[i] = h16[0]; a_vf[i] = vf[0]; a_hf[i] = hf[0];
    endtask

    task automatic pulse_line(input int line);
        @(negedge clk);
        line_num   = 8'(line);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " completes"}, 32'(cyc < 2000), 1);
    endtask

    task automatic run_line(input string name, input int line);
        build_expect(line);
        act_wr.delete();
        act_fetch.delete();
        pulse_line(line);
        wait_idle(name);
        @(negedge clk);
        check({name, " leftover writes"}, exp_wr.size(), 0);
        check({name, " leftover fetches"}, exp_fetch.size(), 0);
        check({name, " overflow"}, spr_overflow, exp_ovf);
    endtask

    // VRAM responder: acknowledge a request after lat cycles, one-cycle ack.
    initial begin
        int wait_cnt = 0;
        vram_ack    = 1'b0;
        vram_rddata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                vram_ack = 1'b0;
                wait_cnt = 0;
            end else if (vram_ack) begin
                vram_ack = 1'b0;
            end else if (vram_req && !hold_ack) begin
                if (wait_cnt >= lat) begin
                    vram_ack    = 1'b1;
                    vram_rddata = mem[vram_addr];
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Compare process: every line-buffer write and accepted fetch against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en && reset) begin
                if (lb_wren) begin
                    act_wr.push_back({lb_addr, lb_wrdata});
                    if (exp_wr.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL lb write: got addr %0d data %0h, expected no write", lb_addr, lb_wrdata);
                    end else begin
                        check("lb write {addr,data}", {lb_addr, lb_wrdata}, exp_wr.pop_front());
                    end
                end
                if (vram_req && vram_ack) begin
                    act_fetch.push_back(vram_addr);
                    if (exp_fetch.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL vram fetch: got addr %0d, expected no fetch", vram_addr);
                    end else begin
                        check("vram fetch addr", vram_addr, exp_fetch.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        reset      = 1'b0;
        line_start = 1'b0;
        line_num   = '0;
        clear_all();
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset vram_req", vram_req, 0);
        check("reset lb_wren", lb_wren, 0);
        check("reset spr_overflow", spr_overflow, 0);
        check("reset spr_sel", spr_sel, 0);
        check("reset vram_addr", vram_addr, 0);
        check("reset lb_addr", lb_addr, 0);
        check("reset lb_wrdata", lb_wrdata, 0);
        reset = 1'b1;
        @(negedge clk);

        // Plain sprite: line 12 hits row 2 of tile 5
        lat = 1;
        set_spr(0, 20, 10, 5, 0, 0, 0, 0, 0);
        mem[42] = 32'h12345670;
        run_line("basic", 12);
        check("basic fetch count", act_fetch.size(), 1);
        check("basic fetch addr", act_fetch[0], 42);
        check("basic write count", act_wr.size(), 7);
        if (act_wr.size() == 7) begin
            check("basic first write", act_wr[0], wr(20, 0, 0, 1));
            check("basic last write", act_wr[6], wr(26, 0, 0, 7));
        end

        // Both flips: row 5, pixels reversed
        lat = 0;
        set_spr(0, 20, 10, 5, 0, 0, 0, 1, 1);
        mem[45] = 32'h12345670;
        run_line("flip", 12);
        check("flip fetch addr", act_fetch[0], 45);
        check("flip write count", act_wr.size(), 7);
        if (act_wr.size() == 7) begin
            check("flip first write", act_wr[0], wr(21, 0, 0, 7));
            check("flip last write", act_wr[6], wr(27, 0, 0, 1));
        end

        // 16-high sprite with y wrap; 8-high misses at dy=10, hits at dy=7
        clear_all();
        lat = 3;
        set_spr(0, 0, 250, 100, 1, 2, 1, 0, 0);
        set_spr(1, 0, 250, 200, 0, 0, 0, 0, 0);
        set_spr(2, 0, 253, 3, 0, 0, 0, 0, 0);
        mem[810] = 32'h0000000A;
        run_line("tall", 4);
        check("tall fetch count", act_fetch.size(), 2);
        check("tall fetch addr", act_fetch[0], 810);
        check("tall 8-high fetch addr", act_fetch[1], 31);
        check("tall write", act_wr[0], wr(7, 1, 2, 10));

        set_spr(0, 0, 250, 100, 1, 2, 1, 1, 0);
        mem[805] = 32'hB0000000;
        run_line("tall vflip", 4);
        check("tall vflip fetch addr", act_fetch[0], 805);
        check("tall vflip write", act_wr[0], wr(0, 1, 2, 11));

        set_spr(0, 0, 250, 1023, 0, 1, 1, 0, 0);
        mem[2] = 32'h0C000000;
        run_line("tile wrap", 4);
        check("tile wrap fetch addr", act_fetch[0], 2);
        check("tile wrap write", act_wr[0], wr(1, 0, 1, 12));

        // Right edge: x=316 clips to 4 pixels; x=510 is entirely off-screen
        clear_all();
        lat = 0;
        set_spr(0, 316, 12, 9, 0, 0, 0, 0, 0);
        set_spr(1, 510, 12, 10, 0, 0, 0, 0, 0);
        mem[72] = 32'hFFFFFFFF;
        mem[80] = 32'hFFFFFFFF;
        run_line("edge", 12);
        check("edge fetch count", act_fetch.size(), 2);
        check("edge write count", act_wr.size(), 4);
        check("edge last write", act_wr[3], wr(319, 0, 0, 15));

        // 21 sprites on line 0 (entries 0..19 and 63)
        clear_all();
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            set_spr(i, i * 16, 0, i + 20, 0, 0, 0, 0, 0);
            mem[(i + 20) * 8] = {4'((i % 15) + 1), 28'h0};
        end
        set_spr(63, 300, 0, 60, 0, 0, 0, 0, 0);
        mem[480] = 32'h0000000F;
        run_line("crowd", 0);
`ifdef SPRITE_LINE_LIMIT_EN
        check("crowd fetch count", act_fetch.size(), 16);
        check("crowd overflow", spr_overflow, 1);
`else
        check("crowd fetch count", act_fetch.size(), 21);
        check("crowd overflow", spr_overflow, 0);
`endif

        // Only entry 63 hits: rendered, then straight to DONE
        for (int i = 0; i < 20; i++) a_y[i] = 8'd200;
        run_line("last entry", 0);
        check("last entry fetch addr", act_fetch[0], 480);
        check("last entry write", act_wr[0], wr(307, 0, 0, 15));
        check("last entry overflow", spr_overflow, 0);

        // Abort during FETCH with the ack held back
        clear_all();
        set_spr(0, 40, 10, 5, 0, 0, 0, 0, 0);
        mem[43] = 32'h11111111;
        build_expect(13);
        act_wr.delete();
        act_fetch.delete();
        hold_ack = 1'b1;
        pulse_line(12);
        cyc = 0;
        while (!vram_req && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("abort reached fetch", vram_req, 1);
        repeat (3) @(negedge clk);
        pulse_line(13);
        check("abort vram_req dropped", vram_req, 0);
        check("abort spr_sel restart", spr_sel, 0);
        check("abort busy", busy, 1);
        hold_ack = 1'b0;
        wait_idle("abort");
        @(negedge clk);
        check("abort leftover writes", exp_wr.size(), 0);
        check("abort fetch count", act_fetch.size(), 1);
        check("abort fetch addr", act_fetch[0], 43);
        check("abort write count", act_wr.size(), 8);

        // Async reset in the middle of RENDER
        check_en = 1'b0;
        set_spr(0, 20, 10, 5, 0, 0, 0, 0, 0);
        mem[42] = 32'hFFFFFFFF;
        pulse_line(12);
        cyc = 0;
        while (!lb_wren && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("reset test reached render", lb_wren, 1);
        #1 reset = 1'b0;
        #1;
        check("async reset lb_wren", lb_wren, 0);
        check("async reset busy", busy, 0);
        check("async reset vram_req", vram_req, 0);
        check("async reset lb_addr", lb_addr, 0);
        check("async reset spr_sel", spr_sel, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_en = 1'b1;

        // Normal operation resumes after reset
        mem[42] = 32'h12345670;
        run_line("after reset", 12);
        check("after reset write count", act_wr.size(), 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_line_eval.md
Name: sprite_line_eval

Overview:
- Per-scanline sprite evaluator and renderer.
- Sits directly downstream of the sprite attribute store: drives its 6-bit sprite select and consumes the decoded attribute fields on the same cycle.
- For the next display line it scans all 64 sprites, fetches the 4bpp pattern row of each sprite that hits the line from VRAM, and writes the opaque pixels into the sprite line buffer.

Parameters:
- NUM_SPR, 64, number of attribute entries scanned (fixed by the 6-bit select).
- MAX_SPR, 16, maximum sprites rendered per line (used only with the optional feature).
- LINE_W, 320, visible width; pixels with x >= LINE_W are dropped.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- line_start  in  1  one-cycle pulse; begin evaluating line line_num.
- line_num  in  8  display line being prepared.
- busy  out  1  high from the cycle after line_start until DONE.
- spr_sel  out  6  attribute entry select (registered).
- spr_x  in  9  sprite x.
- spr_y  in  8  sprite y.
- spr_idx  in  10  tile index.
- spr_priority  in  1  priority flag.
- spr_palette  in  2  palette.
- spr_h16  in  1  16-pixel-high sprite.
- spr_vflip  in  1  vertical flip.
- spr_hflip  in  1  horizontal flip.
- vram_addr  out  13  32-bit word address: {tile[9:0], row[2:0]}.
- vram_req  out  1  read request; held until ack.
- vram_ack  in  1  read complete; vram_rddata valid in the same cycle.
- vram_rddata  in  32  8 pixels; pixel p = bits [31-4p -: 4].
- lb_addr  out  9  line buffer x.
- lb_wrdata  out  7  {priority, palette[1:0], color[3:0]}.
- lb_wren  out  1  line buffer write strobe.
- spr_overflow  out  1  more than MAX_SPR sprites hit the line.

Behaviour:
- Reset values: busy, vram_req, lb_wren, spr_overflow = 0; spr_sel, vram_addr, lb_addr, lb_wrdata = 0; state = IDLE.
- States: IDLE, SCAN, FETCH, RENDER, DONE.
- IDLE, on line_start: latch line_num, spr_sel <= 0, count <= 0, spr_overflow <= 0, go to SCAN.
- SCAN, one cycle per entry. Attributes are valid combinationally for the current spr_sel.
  - dy = line - spr_y, mod 256; h = spr_h16 ? 16 : 8.
  - Hit when dy < h.
  - Hit: latch the attribute fields; row = vflip ? h-1-dy : dy; tile = spr_idx + row[3] (10-bit wrap); go to FETCH.
  - Miss: spr_sel++; after entry 63, go to DONE.
- FETCH: vram_req = 1 with vram_addr = {tile, row[2:0]}. On vram_ack, latch data and go to RENDER.
- RENDER: 8 cycles, pixel p = 0..7.
  - Source nibble = hflip ? pixel 7-p : pixel p.
  - x = spr_x + p, 10-bit sum.
  - lb_wren = 1 only if nibble != 0 and x < LINE_W. No wrap.
  - lb_addr = x[8:0].
  - After p = 7: count++, spr_sel++; go to SCAN, or to DONE if entry 63 was just processed.
- Line buffer contract: the first write to an x location wins. Lower sprite index therefore has display priority. The line buffer enforces this with its own write-once mask.
- DONE: busy drops next cycle; return to IDLE.
- line_start in any non-IDLE state: abort immediately.
  - Deassert vram_req and lb_wren.
  - Restart at entry 0 with the new line_num. An outstanding ack is ignored.
- Async reset mid-operation: everything returns to reset values at once.
- Worst-case latency: 64 + 16*(fetch + 8) cycles. The caller must issue line_start at least that long before the line is displayed.

Optional Feature:
- Macro: SPRITE_LINE_LIMIT_EN.
- Defined:
  - In SCAN, a hit with count == MAX_SPR sets spr_overflow (sticky until the next line_start).
  - That sprite is skipped, and so are all later entries; the block goes to DONE.
- Undefined:
  - Every hitting sprite is rendered; MAX_SPR is ignored.
  - spr_overflow is tied to 0.

Decomposition:
- Shared Verilog include holds:
  - state encodings;
  - LINE_W;
  - the lb_wrdata field layout;
  - the pixel nibble ordering, shared with the line buffer and the compositor.
- One natural sub-module, spr_row_shifter: 32-bit row register plus pixel counter with the hflip mux. It outputs a nibble per cycle and a last flag.

Test Plan:
- Sprite 0 at y=10, x=20, idx=5, h16=0. line_start with line 12 -> vram_addr = {5,3'd2}. Ack data 0x12345670 -> 7 writes at x=20..26 with colors 1..7; no write at x=27.
- Same sprite with hflip=1 and vflip=1 -> vram_addr row 5. Writes x=21..27 with colors 7..1.
- h16=1, y=250, line 4 (dy=10, wrap) -> tile idx+1, row 2. vflip=1 -> tile idx, row 5.
- x=316, data all 0xF -> writes only x=316..319; no write at x >= 320.
- 20 sprites on line 0, with SPRITE_LINE_LIMIT_EN -> exactly 16 fetches and spr_overflow=1. Without the macro -> 20 fetches and spr_overflow=0.
- line_start asserted during FETCH with ack pending -> vram_req drops next cycle and the scan restarts at spr_sel=0. Async reset during RENDER -> lb_wren=0 and busy=0 immediately.
